// File: rtl/imm_extend_stage.sv
// Registered immediate-extension stage: zero/sign/scaled extension plus a
// two-beat long immediate, with valid/ready handshakes on both sides.
module imm_extend_stage #(
  parameter int unsigned INSTR_W = 24,
  parameter int unsigned DATA_W  = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSTR_W-1:0]  in_instr,
  input  logic [1:0]          in_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_imm
);

  localparam int unsigned LONG_W = 2 * INSTR_W;
  localparam int unsigned SEXT_W = DATA_W - INSTR_W;
  localparam int unsigned LEXT_W = DATA_W - LONG_W;

  localparam logic [1:0] MODE_ZERO   = 2'd0;
  localparam logic [1:0] MODE_SIGN   = 2'd1;
  localparam logic [1:0] MODE_SCALED = 2'd2;
  localparam logic [1:0] MODE_LONG   = 2'd3;

  typedef enum logic {IDLE, HI_HELD} state_t;

  state_t               state, state_nx;
  logic [INSTR_W-1:0]   hi_reg, hi_nx;
  logic                 accept;
  logic                 load;
  logic [DATA_W-1:0]    result;
  logic [DATA_W-1:0]    sext_imm;

  // Backpressure: a new beat only enters when the output slot is free or draining.
  assign in_ready = rst_n && !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign sext_imm = {{SEXT_W{in_instr[INSTR_W-1]}}, in_instr};

  // Next-state, hi capture and result selection.
  always_comb begin
    state_nx = state;
    hi_nx    = hi_reg;
    load     = 1'b0;
    result   = '0;
    if (accept) begin
      case (state)
        IDLE: begin
          unique case (in_mode)
            MODE_ZERO: begin
              load   = 1'b1;
              result = {{SEXT_W{1'b0}}, in_instr};
            end
            MODE_SIGN: begin
              load   = 1'b1;
              result = sext_imm;
            end
            MODE_SCALED: begin
              load   = 1'b1;
              result = sext_imm << 2;
            end
            MODE_LONG: begin
              state_nx = HI_HELD;
              hi_nx    = in_instr;
            end
            default: ;
          endcase
        end
        HI_HELD: begin
          // Second beat is always the low half; its mode field is ignored.
          load     = 1'b1;
          result   = {{LEXT_W{hi_reg[INSTR_W-1]}}, hi_reg, in_instr};
          state_nx = IDLE;
          hi_nx    = '0;
        end
        default: state_nx = IDLE;
      endcase
    end
    if (flush) begin
      state_nx = IDLE;
      hi_nx    = '0;
    end
  end

  // State, hi half and output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      hi_reg    <= '0;
      out_valid <= 1'b0;
      out_imm   <= '0;
    end else begin
      state  <= state_nx;
      hi_reg <= hi_nx;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (load) begin
        out_valid <= 1'b1;
        out_imm   <= result;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imm_extend_stage.sv
// Directed bench for imm_extend_stage with a cycle-level reference model
// compared every cycle, plus literal expectations from hand calculation.
module tb_imm_extend_stage;

  localparam int unsigned INSTR_W = 24;
  localparam int unsigned DATA_W  = 64;

  logic               clk;
  logic               rst_n;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [1:0]         in_mode;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_imm;

  int total = 0;
  int bad   = 0;

  imm_extend_stage #(.INSTR_W(INSTR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: value-level arithmetic on a W-bit field.
  function automatic longint sx(input longint v, input int w);
    longint half = longint'(1) <<< (w - 1);
    return (v >= half) ? v - (half <<< 1) : v;
  endfunction

  bit        m_valid;
  bit [63:0] m_imm;
  bit        m_held;
  longint    m_hi;
  bit [63:0] rel_q[$];

  function automatic bit m_in_ready();
    return rst_n && !flush && (!m_valid || out_ready);
  endfunction

  always @(posedge clk) begin
    bit     acc, produce;
    longint v, val;
    acc     = in_valid && m_in_ready();
    produce = 1'b0;
    val     = 0;
    v       = longint'(in_instr);
    if (!rst_n) begin
      m_valid = 0; m_imm = 0; m_held = 0; m_hi = 0;
    end else if (flush) begin
      m_valid = 0; m_held = 0; m_hi = 0;
    end else begin
      if (acc) begin
        if (m_held) begin
          val = sx(m_hi * (longint'(1) <<< INSTR_W) + v, 2 * INSTR_W);
          produce = 1; m_held = 0; m_hi = 0;
        end else if (in_mode == 2'd3) begin
          m_held = 1; m_hi = v;
        end else begin
          produce = 1;
          case (in_mode)
            2'd0:    val = v;
            2'd1:    val = sx(v, INSTR_W);
            default: val = sx(v, INSTR_W) * 4;
          endcase
        end
      end
      if (produce) begin
        m_valid = 1; m_imm = 64'(val);
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
    end
  end

  // Per-cycle comparison against the model, and a log of released results.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("in_ready", 64'(in_ready), 64'(m_in_ready()));
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("out_imm", out_imm, m_imm);
      if (rst_n && out_valid && out_ready) rel_q.push_back(out_imm);
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present a beat and hold it until accepted (bounded).
  task automatic beat(input logic [1:0] mode, input logic [INSTR_W-1:0] instr);
    bit ok;
    int n;
    in_valid = 1'b1; in_mode = mode; in_instr = instr;
    n = 0;
    do begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1; n++;
    end while (!ok && n < 50);
    if (!ok) chk("accept_timeout", 64'(ok), 64'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_mode = '0; out_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_imm", out_imm, 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    idle(1);

    beat(2'd0, 24'h800001);
    chk("zero", out_imm, 64'h0000_0000_0080_0001);
    chk("zero_valid", 64'(out_valid), 64'd1);

    beat(2'd1, 24'h800001);
    chk("sign_neg", out_imm, 64'hFFFF_FFFF_FF80_0001);
    beat(2'd1, 24'h7FFFFF);
    chk("sign_pos", out_imm, 64'h0000_0000_007F_FFFF);
    beat(2'd2, 24'hFFFFFF);
    chk("scaled_neg", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    beat(2'd2, 24'h000004);
    chk("scaled_pos", out_imm, 64'h0000_0000_0000_0010);
    idle(1);

    beat(2'd3, 24'h800000);
    chk("long_first_no_out", 64'(out_valid), 64'd0);
    idle(3);
    chk("long_held_no_out", 64'(out_valid), 64'd0);
    beat(2'd0, 24'h000001);
    chk("long", out_imm, 64'hFFFF_8000_0000_0001);
    chk("long_model", m_imm, 64'hFFFF_8000_0000_0001);
    idle(2);

    rel_q.delete();
    out_ready = 1'b0;
    beat(2'd1, 24'h000003);
    in_valid = 1'b1; in_mode = 2'd1; in_instr = 24'h000007;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_imm", out_imm, 64'h3);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    beat(2'd1, 24'h000007);
    chk("bp_next", out_imm, 64'h7);
    idle(3);
    chk("bp_rel_count", 64'(rel_q.size()), 64'd2);
    if (rel_q.size() == 2) begin
      chk("bp_rel0", rel_q[0], 64'h3);
      chk("bp_rel1", rel_q[1], 64'h7);
    end

    beat(2'd3, 24'h123456);
    flush = 1'b1; in_valid = 1'b1; in_mode = 2'd1; in_instr = 24'h000099;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    beat(2'd1, 24'h000005);
    chk("flush_recover", out_imm, 64'h5);
    idle(2);

    beat(2'd3, 24'h123456);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    beat(2'd1, 24'h000005);
    chk("rst_recover", out_imm, 64'h5);
    idle(2);

    out_ready = 1'b0;
    beat(2'd1, 24'h000042);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_imm", out_imm, 64'h0);
    rst_n = 1'b1; out_ready = 1'b1;
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_extend_stage.md
# imm_extend_stage

- Parametrised, registered immediate-extension stage for the decode pipeline.
- Takes the immediate field of an instruction word plus an extension mode and produces a DATA_W-bit immediate.
- Modes: zero-extend, sign-extend, word-scaled sign-extend (branch offsets), and a two-beat long immediate that joins the fields of two consecutive instruction words.
- Sits between instruction fetch/decode and the register-read stage, with valid/ready handshakes on both sides.

## Interface

Parameters:
- INSTR_W, 24, width of the immediate field per instruction word
- DATA_W, 64, output immediate width; must satisfy DATA_W >= 2*INSTR_W + 2

Ports:
- clk  input  1  sole clock; all state changes on the rising edge
- rst_n  input  1  synchronous, active-low reset
- flush  input  1  synchronous pipeline flush; discards held and pending state
- in_valid  input  1  upstream presents in_instr/in_mode
- in_ready  output  1  stage accepts a beat this cycle
- in_instr  input  INSTR_W  immediate field of the instruction
- in_mode  input  2  0 ZERO, 1 SIGN, 2 SCALED, 3 LONG
- out_valid  output  1  out_imm holds a valid result
- out_ready  input  1  downstream accepts the result
- out_imm  output  DATA_W  extended immediate

## Operation

- Accept: a beat is accepted when in_valid && in_ready.
- Release: a result is released when out_valid && out_ready.
- in_ready = rst_n && !flush && (!out_valid || out_ready), evaluated combinationally.
- ZERO: out_imm = zero-extended in_instr.
- SIGN: out_imm = in_instr sign-extended from bit INSTR_W-1.
- SCALED: out_imm = (sign-extended in_instr) << 2. Arithmetic is DATA_W wide and the upper bits are discarded.
- LONG, two beats:
  - First accepted beat with mode 3 stores in_instr in hi_reg. The FSM moves IDLE -> HI_HELD. No output is produced.
  - The next accepted beat is taken as the low half and its in_mode is ignored.
  - out_imm = {hi_reg, lo} (2*INSTR_W bits), sign-extended from bit 2*INSTR_W-1. The FSM moves HI_HELD -> IDLE.
- FSM states: IDLE, HI_HELD.
  - IDLE -> HI_HELD on an accepted mode-3 beat.
  - HI_HELD -> IDLE on the accepted second beat, flush, or reset.
- Output register:
  - Loads on any result-producing accept; out_valid is set to 1.
  - Clears out_valid on a release without a simultaneous load.
  - A simultaneous release and load gives back-to-back output, with out_valid staying 1.
- Held data: out_imm is stable while out_valid && !out_ready.
- Flush has priority over accept:
  - in_ready is 0 during the flush cycle.
  - Next cycle: state = IDLE, out_valid = 0, hi_reg = 0.
  - out_imm keeps its value but is invalid.
- Reset, including mid-operation in HI_HELD or with out_valid = 1:
  - Next cycle: state = IDLE, out_valid = 0, out_imm = 0, hi_reg = 0.
  - in_ready = 0 while rst_n = 0.

## Timing

- Single-beat modes: accept in cycle N -> out_valid = 1 with result in cycle N+1.
- LONG: second-beat accept in cycle N -> result in cycle N+1. No output follows the first beat.
- Throughput: one result per cycle when out_ready = 1 every cycle.
- A LONG op occupies two input beats.
- Backpressure: while out_valid = 1 and out_ready = 0, in_ready = 0, so no beats are lost or overwritten.
- HI_HELD persists indefinitely while the upstream stalls (in_valid = 0).
- Reset values: out_valid 0, out_imm 0, in_ready 0 (combinational, while rst_n = 0), FSM IDLE.

## Test plan

All values use INSTR_W=24, DATA_W=64.

- ZERO, in_instr=0x800001 -> next cycle out_valid=1, out_imm=0x0000_0000_0080_0001.
- SIGN 0x800001 then SIGN 0x7FFFFF, back-to-back with out_ready=1 -> 0xFFFF_FFFF_FF80_0001, then 0x0000_0000_007F_FFFF, on consecutive cycles.
- SCALED 0xFFFFFF -> 0xFFFF_FFFF_FFFF_FFFC; SCALED 0x000004 -> 0x0000_0000_0000_0010.
- LONG hi=0x800000, then lo=0x000001 (second beat's mode = 0):
  - out_valid stays 0 after the first beat.
  - After the second beat, out_imm = 0xFFFF_8000_0000_0001.
- Backpressure: SIGN 0x000003 accepted, then out_ready=0 for 3 cycles:
  - out_valid=1 and out_imm=0x3 stay stable; in_ready=0.
  - On release, the pending next beat is accepted with no loss or duplication.
- Flush and reset recovery:
  - LONG first beat 0x123456, then flush=1 for one cycle, then SIGN 0x000005 -> out_imm=0x5 (no stale hi).
  - Repeat with rst_n=0 in place of flush -> same result.
  - Reset with out_valid=1 -> out_valid=0 and out_imm=0 on the next cycle.
